req_pend_arb: RTL and testbench
===============================

// Module: req_pend_arb
// PURPOSE
//   Upstream stage that feeds the N-bit priority index encoder.
//   - Captures single-cycle request pulses into sticky pending bits and applies a per-bit mask.
//   - Selects the highest-index eligible request and presents its index on a valid/ready handshake.
//   - Clears the serviced pending bit on handshake.
//   - Counts coalesced requests, i.e. those that arrive while their bit is already pending.
// PARAMETERS
//   N   3       index width
//   M   1<<N    number of request lines
//   CW  8       width of saturating coalesce counter
// PORTS
//   clk         in   1      single clock, rising edge
//   rst_n       in   1      asynchronous active-low reset
//   req_i       in   M      request pulses; bit k high for one or more cycles requests service of k
//   mask_i      in   M      1 = bit ineligible for selection (still latched into pending)
//   out_valid   out  1      out_idx holds a granted request
//   out_ready   in   1      consumer accepts out_idx this cycle when out_valid=1
//   out_idx     out  N      granted request index
//   pending_o   out  M      current sticky pending vector
//   coal_cnt_o  out  CW     saturating count of coalesced requests
// BEHAVIOUR
//   Reset: pending=0, out_valid=0, out_idx=0, coal_cnt=0, FSM=IDLE.
//     - Reset applies immediately and mid-handshake; any offered index is dropped.
//   Pending update, every cycle: pending_next = (pending & ~clr) | req_i.
//     - clr is a one-hot of out_idx only in a handshake cycle (out_valid & out_ready), else 0.
//     - Set wins: req_i[k] in the same cycle as clearing k leaves k pending.
//   Eligible vector: elig = pending & ~mask_i. Uses registered pending, not req_i.
//   Selection: highest set index of elig.
//     - elig=0 yields no grant; index 0 is granted only if elig[0]=1.
//   FSM:
//     - IDLE:  if elig!=0, register out_idx=sel, assert out_valid -> OFFER.
//              Else stay in IDLE with out_valid=0.
//     - OFFER: out_valid=1; out_idx is held stable even if a higher index arrives or mask_i changes.
//              On out_ready=1 the handshake completes: clear the bit, deassert out_valid -> IDLE.
//              On out_ready=0 stay in OFFER.
//   Latency:
//     - req_i pulse at cycle t -> pending at t+1 -> out_valid at t+2.
//     - Throughput is at most one grant per 2 cycles, because IDLE is always visited between grants.
//   Coalesce: each cycle, coal_cnt += popcount(req_i & pending & ~clr).
//     - Saturates at 2^CW-1 and never wraps.
//     - A request on a bit being cleared in the same cycle is not counted.
//   All outputs are registered; there are no combinational paths from out_ready or mask_i to outputs.
// STRUCTURE
//   Shared package:
//     - FSM state enum {IDLE, OFFER}.
//     - Function onehot(idx) -> M-bit vector.
//     - Function popcount(M-bit) -> $clog2(M+1) bits.
//   One sub-module, prio_idx_enc (combinational: elig[M-1:0] -> sel[N-1:0] plus any_o).
//     - Highest index wins.
//   The rest lives in this module: pending register, FSM, coalesce counter.
// TESTING
//   1. Reset then idle.
//      Stimulus: rst_n low 3 cycles, release, req_i=0 for 10 cycles.
//      Required: out_valid=0, pending_o=0, coal_cnt_o=0 throughout.
//   2. Priority.
//      Stimulus: req_i=8'h12 for 1 cycle, out_ready=1.
//      Required: grant idx 4 at t+2, then idx 1 at t+4, then out_valid=0, pending_o=0.
//   3. Stability under backpressure.
//      Stimulus: req bit 2, out_ready=0; raise req bit 7 while idx 2 is offered.
//      Required: out_idx stays 2 until ready=1; next grant is 7.
//   4. Mask.
//      Stimulus: mask_i=8'h80, req_i=8'h81.
//      Required: grant idx 0 only; pending_o=8'h80 remains.
//      Clear mask_i -> idx 7 granted 1 cycle later.
//   5. Set-wins and coalesce.
//      - Pulse bit 3 while pending[3]=1 and no grant -> coal_cnt_o +1.
//      - Pulse bit 3 in its handshake cycle -> pending[3] stays 1, no count.
//      - Hold req bit 5 for 300 cycles -> coal_cnt_o saturates at 255.
//   6. Reset mid-OFFER.
//      Stimulus: assert rst_n=0 asynchronously while out_valid=1.
//      Required: out_valid=0 and pending_o=0 before the next clk edge; after release, no stale grant.

Source files
------------

// File: rtl/req_pend_arb_pkg.sv
// Shared types and helpers for the request-pending arbiter: FSM states, one-hot decode, popcount.
// Pure declarations; no timing or backpressure of its own.
package req_pend_arb_pkg;

  localparam int IDX_W = 3;
  localparam int REQ_N = 1 << IDX_W;
  localparam int CNT_W = 8;
  localparam int PC_W  = $clog2(REQ_N + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  function automatic logic [REQ_N-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [REQ_N-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  function automatic logic [PC_W-1:0] popcount(input logic [REQ_N-1:0] v);
    logic [PC_W-1:0] c;
    c = '0;
    for (int i = 0; i < REQ_N; i++) begin
      c = c + PC_W'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/req_pend_arb_prio_idx_enc.sv
// Priority index encoder: highest set bit of elig wins; combinational, zero latency.
// No backpressure; any_o low means sel is meaningless (driven to 0).
module prio_idx_enc #(
  parameter int N = 3,
  parameter int M = 1 << N
) (
  input  logic [M-1:0] elig,
  output logic [N-1:0] sel,
  output logic         any_o
);

  always_comb begin
    sel = '0;
    // Ascending scan so the last hit, i.e. the highest index, is what remains.
    for (int i = 0; i < M; i++) begin
      if (elig[i]) begin
        sel = N'(i);
      end
    end
  end

  assign any_o = |elig;

endmodule

// File: rtl/req_pend_arb.sv
// Sticky request capture, masked highest-index grant on valid/ready, coalesce counter; req->valid 2 cycles.
// out_idx is held while out_ready is low; IDLE is visited between grants so at most one grant per 2 cycles.
module req_pend_arb
  import req_pend_arb_pkg::*;
#(
  parameter int N  = IDX_W,
  parameter int M  = 1 << N,
  parameter int CW = CNT_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [M-1:0]  req_i,
  input  logic [M-1:0]  mask_i,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_idx,
  output logic [M-1:0]  pending_o,
  output logic [CW-1:0] coal_cnt_o
);

  state_t          state;
  state_t          state_nxt;
  logic            valid_nxt;
  logic [N-1:0]    idx_nxt;
  logic [M-1:0]    elig;
  logic [N-1:0]    sel;
  logic            any_elig;
  logic            hs;
  logic [M-1:0]    clr;
  logic [M-1:0]    pending_nxt;
  logic [PC_W-1:0] coal_add;
  logic [CW:0]     cnt_sum;
  logic [CW-1:0]   cnt_nxt;

  // Selection looks only at the registered pending vector, never at req_i directly.
  assign elig = pending_o & ~mask_i;

  prio_idx_enc #(
    .N (N),
    .M (M)
  ) u_enc (
    .elig  (elig),
    .sel   (sel),
    .any_o (any_elig)
  );

  assign hs  = out_valid & out_ready;
  assign clr = hs ? onehot(out_idx) : '0;

  // Set wins over clear: a fresh request on the serviced bit keeps it pending.
  assign pending_nxt = (pending_o & ~clr) | req_i;

  assign coal_add = popcount(req_i & pending_o & ~clr);
  assign cnt_sum  = {1'b0, coal_cnt_o} + (CW+1)'(coal_add);
  assign cnt_nxt  = cnt_sum[CW] ? {CW{1'b1}} : cnt_sum[CW-1:0];

  always_comb begin
    state_nxt = state;
    valid_nxt = out_valid;
    idx_nxt   = out_idx;
    case (state)
      IDLE: begin
        valid_nxt = 1'b0;
        if (any_elig) begin
          state_nxt = OFFER;
          valid_nxt = 1'b1;
          idx_nxt   = sel;
        end
      end
      OFFER: begin
        valid_nxt = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
          valid_nxt = 1'b0;
        end
      end
      default: begin
        state_nxt = IDLE;
        valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      out_valid  <= 1'b0;
      out_idx    <= '0;
      pending_o  <= '0;
      coal_cnt_o <= '0;
    end else begin
      state      <= state_nxt;
      out_valid  <= valid_nxt;
      out_idx    <= idx_nxt;
      pending_o  <= pending_nxt;
      coal_cnt_o <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_req_pend_arb.sv
// Directed bench: per-cycle comparison against a behavioural arbiter model plus literal spot checks.
module tb_req_pend_arb;

  logic       clk;
  logic       rst_n;
  logic [7:0] req_i;
  logic [7:0] mask_i;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_idx;
  logic [7:0] pending_o;
  logic [7:0] coal_cnt_o;

  int n_chk  = 0;
  int n_fail = 0;
  bit run_cmp = 0;

  req_pend_arb dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_i      (req_i),
    .mask_i     (mask_i),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_idx    (out_idx),
    .pending_o  (pending_o),
    .coal_cnt_o (coal_cnt_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model: a set of pending request numbers, an offered index, a capped count.
  bit m_pend [8];
  bit m_valid;
  int m_idx;
  int m_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 8; k++) m_pend[k] = 0;
      m_valid = 0;
      m_idx   = 0;
      m_cnt   = 0;
    end else begin
      bit nxt [8];
      bit serviced;
      for (int k = 0; k < 8; k++) begin
        serviced = m_valid && out_ready && (k == m_idx);
        if (req_i[k] && m_pend[k] && !serviced && m_cnt < 255) m_cnt = m_cnt + 1;
        nxt[k] = req_i[k] || (m_pend[k] && !serviced);
      end
      if (m_valid) begin
        if (out_ready) m_valid = 0;
      end else begin
        for (int k = 7; k >= 0; k--) begin
          if (!m_valid && m_pend[k] && !mask_i[k]) begin
            m_valid = 1;
            m_idx   = k;
          end
        end
      end
      for (int k = 0; k < 8; k++) m_pend[k] = nxt[k];
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && run_cmp) begin
      logic [7:0] mp;
      for (int k = 0; k < 8; k++) mp[k] = m_pend[k];
      chk("model out_valid", int'(out_valid), int'(m_valid));
      chk("model pending", int'(pending_o), int'(mp));
      chk("model coal_cnt", int'(coal_cnt_o), m_cnt);
      if (m_valid) chk("model out_idx", int'(out_idx), m_idx);
    end
  end

  // Waits for the next falling edge (outputs from the last rising edge are visible), then drives inputs.
  task automatic cyc(input logic [7:0] r, input logic [7:0] m, input logic rd);
    @(negedge clk);
    req_i     = r;
    mask_i    = m;
    out_ready = rd;
  endtask

  task automatic see(input string name, input logic v, input int idx, input int pend);
    chk({name, " valid"}, int'(out_valid), int'(v));
    if (v) chk({name, " idx"}, int'(out_idx), idx);
    chk({name, " pending"}, int'(pending_o), pend);
  endtask

  initial begin
    rst_n = 1'b0; req_i = '0; mask_i = '0; out_ready = 1'b0;

    // 1. reset then idle
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset valid", int'(out_valid), 0);
    chk("reset idx", int'(out_idx), 0);
    chk("reset cnt", int'(coal_cnt_o), 0);
    rst_n = 1'b1;
    run_cmp = 1;
    for (int i = 0; i < 10; i++) begin
      cyc(8'h00, 8'h00, 1'b1);
      see("idle", 1'b0, 0, 0);
      chk("idle cnt", int'(coal_cnt_o), 0);
    end

    // 2. priority: 0x12 -> idx 4 then idx 1
    cyc(8'h12, 8'h00, 1'b1);
    cyc(8'h00, 8'h00, 1'b1); see("prio t+1", 1'b0, 0, 8'h12);
    cyc(8'h00, 8'h00, 1'b1); see("prio g4", 1'b1, 4, 8'h12);
    cyc(8'h00, 8'h00, 1'b1); see("prio gap", 1'b0, 0, 8'h02);
    cyc(8'h00, 8'h00, 1'b1); see("prio g1", 1'b1, 1, 8'h02);
    cyc(8'h00, 8'h00, 1'b1); see("prio done", 1'b0, 0, 8'h00);

    // 3. stability under backpressure
    cyc(8'h04, 8'h00, 1'b0);
    cyc(8'h00, 8'h00, 1'b0);
    cyc(8'h00, 8'h00, 1'b0); see("bp g2", 1'b1, 2, 8'h04);
    cyc(8'h80, 8'h00, 1'b0); see("bp hold a", 1'b1, 2, 8'h04);
    cyc(8'h00, 8'h00, 1'b0); see("bp hold b", 1'b1, 2, 8'h84);
    cyc(8'h00, 8'h00, 1'b1); see("bp hold c", 1'b1, 2, 8'h84);
    cyc(8'h00, 8'h00, 1'b1); see("bp acc", 1'b0, 0, 8'h80);
    cyc(8'h00, 8'h00, 1'b1); see("bp g7", 1'b1, 7, 8'h80);
    cyc(8'h00, 8'h00, 1'b1); see("bp done", 1'b0, 0, 8'h00);

    // 4. mask
    cyc(8'h81, 8'h80, 1'b1);
    cyc(8'h00, 8'h80, 1'b1); see("mask t+1", 1'b0, 0, 8'h81);
    cyc(8'h00, 8'h80, 1'b1); see("mask g0", 1'b1, 0, 8'h81);
    cyc(8'h00, 8'h80, 1'b1); see("mask left", 1'b0, 0, 8'h80);
    cyc(8'h00, 8'h80, 1'b1); see("mask held", 1'b0, 0, 8'h80);
    cyc(8'h00, 8'h00, 1'b1); see("unmask", 1'b0, 0, 8'h80);
    cyc(8'h00, 8'h00, 1'b1); see("unmask g7", 1'b1, 7, 8'h80);
    cyc(8'h00, 8'h00, 1'b1); see("mask done", 1'b0, 0, 8'h00);

    // 5. coalesce and set-wins
    cyc(8'h08, 8'h08, 1'b1);
    cyc(8'h00, 8'h08, 1'b1); see("coal set", 1'b0, 0, 8'h08);
    cyc(8'h08, 8'h08, 1'b1); chk("coal before", int'(coal_cnt_o), 0);
    cyc(8'h00, 8'h00, 1'b0); chk("coal +1", int'(coal_cnt_o), 1);
    cyc(8'h08, 8'h00, 1'b1); see("sw offer", 1'b1, 3, 8'h08);
    cyc(8'h00, 8'h00, 1'b1); see("sw kept", 1'b0, 0, 8'h08);
    chk("sw no count", int'(coal_cnt_o), 1);
    cyc(8'h00, 8'h00, 1'b1); see("sw regrant", 1'b1, 3, 8'h08);
    cyc(8'h00, 8'h00, 1'b1); see("sw done", 1'b0, 0, 8'h00);
    for (int i = 0; i < 300; i++) cyc(8'h20, 8'h00, 1'b0);
    cyc(8'h00, 8'h00, 1'b0); chk("sat cnt", int'(coal_cnt_o), 255);
    cyc(8'h20, 8'h00, 1'b0); chk("sat hold", int'(coal_cnt_o), 255);
    cyc(8'h00, 8'h00, 1'b1); chk("sat no wrap", int'(coal_cnt_o), 255);
    cyc(8'h00, 8'h00, 1'b1); see("sat drain", 1'b0, 0, 8'h00);

    // 6. asynchronous reset while offering
    cyc(8'h02, 8'h00, 1'b0);
    cyc(8'h00, 8'h00, 1'b0);
    cyc(8'h00, 8'h00, 1'b0); see("rst pre", 1'b1, 1, 8'h02);
    #2 rst_n = 1'b0;
    #1;
    chk("async valid", int'(out_valid), 0);
    chk("async pending", int'(pending_o), 0);
    chk("async cnt", int'(coal_cnt_o), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(8'h00, 8'h00, 1'b1);
      see("post rst", 1'b0, 0, 8'h00);
    end

    run_cmp = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
